// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU-facing I/O register blocks.
// Widths and the read-handshake state enum are common to input and output registers.
package cpu_io_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 5;
    localparam int SLOTS  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/input_register.sv
// Slot-addressed input register file between an external producer and the CPU.
// A CPU read of an empty slot stalls until data arrives (bypass) or the timeout expires.
module input_register
    import cpu_io_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [IDX_W-1:0]  ext_index,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic [IDX_W-1:0]  cpu_index,
    input  logic              cpu_read_enable,
    output logic [DATA_W-1:0] cpu_value,
    output logic              cpu_data_valid,
    output logic              cpu_busy,
    output logic              cpu_timeout,
    output logic [SLOTS-1:0]  slot_full,
    output logic              timeout_sticky,
    input  logic              clear_status
);

    logic [DATA_W-1:0] r_mem [SLOTS];
    state_t            r_state;
    logic [IDX_W-1:0]  r_rdIdx;
    logic [7:0]        r_count;

    logic w_waitHit;
    logic w_accept;
    logic w_bypass;
    logic w_store;

    // The slot a stalled read is waiting on always accepts, so the producer can feed the bypass.
    assign w_waitHit = (r_state == WAIT) && (ext_index == r_rdIdx);
    assign ext_ready = w_waitHit ? 1'b1 : !slot_full[ext_index];
    assign w_accept  = ext_valid && ext_ready;
    assign w_bypass  = w_accept && w_waitHit;
    assign w_store   = w_accept && !w_bypass;
    assign cpu_busy  = (r_state == WAIT);

    // Storage carries no reset; slot_full decides whether its contents are meaningful.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[ext_index] <= ext_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rdIdx        <= '0;
            r_count        <= '0;
            slot_full      <= '0;
            cpu_value      <= '0;
            cpu_data_valid <= 1'b0;
            cpu_timeout    <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            cpu_data_valid <= 1'b0;
            cpu_timeout    <= 1'b0;

            if (clear_status) begin
                timeout_sticky <= 1'b0;
            end

            if (w_store) begin
                slot_full[ext_index] <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (cpu_read_enable) begin
                        if (slot_full[cpu_index]) begin
                            cpu_value            <= r_mem[cpu_index];
                            slot_full[cpu_index] <= 1'b0;
                            cpu_data_valid       <= 1'b1;
                        end else begin
                            r_rdIdx <= cpu_index;
                            r_count <= '0;
                            r_state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    // Arriving data wins over a timeout expiring in the same cycle.
                    if (w_bypass) begin
                        cpu_value      <= ext_data;
                        cpu_data_valid <= 1'b1;
                        r_state        <= IDLE;
                    end else if (r_count == TIMEOUT - 8'd1) begin
                        cpu_value      <= '0;
                        cpu_data_valid <= 1'b1;
                        cpu_timeout    <= 1'b1;
                        timeout_sticky <= 1'b1;
                        r_state        <= IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_register.sv
// Self-checking bench for input_register: directed scenarios plus a randomized run
// compared against a slot/pending-read reference model.
module tb_input_register;

    localparam logic [7:0] TO_SHORT = 8'd4;

    logic        clk;
    logic        rst;
    logic [7:0]  extData;
    logic [4:0]  extIndex;
    logic        extValid;
    logic [4:0]  cpuIndex;
    logic        cpuReadEnable;
    logic        clearStatus;

    logic        sReady, sValid, sBusy, sTimeout, sSticky;
    logic [7:0]  sValue;
    logic [31:0] sFull;
    logic        lReady, lValid, lBusy, lTimeout, lSticky;
    logic [7:0]  lValue;
    logic [31:0] lFull;

    int errors = 0;
    int checks = 0;

    // Reference model: slot contents, occupancy and one pending read with elapsed wait cycles.
    logic [7:0]  mMem [32];
    logic [31:0] mFull = '0;
    logic [7:0]  mValue = '0;
    logic        mValid = 1'b0;
    logic        mTimeout = 1'b0;
    logic        mSticky = 1'b0;
    logic        mWaiting = 1'b0;
    logic [4:0]  mWaitIdx = '0;
    int          mElapsed = 0;

    input_register #(.TIMEOUT(TO_SHORT)) dutShort (
        .clk(clk), .rst(rst), .ext_data(extData), .ext_index(extIndex),
        .ext_valid(extValid), .ext_ready(sReady), .cpu_index(cpuIndex),
        .cpu_read_enable(cpuReadEnable), .cpu_value(sValue), .cpu_data_valid(sValid),
        .cpu_busy(sBusy), .cpu_timeout(sTimeout), .slot_full(sFull),
        .timeout_sticky(sSticky), .clear_status(clearStatus)
    );

    input_register dutLong (
        .clk(clk), .rst(rst), .ext_data(extData), .ext_index(extIndex),
        .ext_valid(extValid), .ext_ready(lReady), .cpu_index(cpuIndex),
        .cpu_read_enable(cpuReadEnable), .cpu_value(lValue), .cpu_data_valid(lValid),
        .cpu_busy(lBusy), .cpu_timeout(lTimeout), .slot_full(lFull),
        .timeout_sticky(lSticky), .clear_status(clearStatus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelReady(input logic [4:0] idx);
        if (mWaiting && idx == mWaitIdx) return 1'b1;
        return !mFull[idx];
    endfunction

    // Advances the model by one clock using the inputs presented to the DUTs this cycle.
    task automatic modelUpdate();
        logic accept;
        if (rst) begin
            mFull = '0; mValue = '0; mValid = 1'b0; mTimeout = 1'b0; mSticky = 1'b0;
            mWaiting = 1'b0; mWaitIdx = '0; mElapsed = 0;
        end else begin
            accept = extValid && modelReady(extIndex);
            mValid = 1'b0;
            mTimeout = 1'b0;
            if (clearStatus) mSticky = 1'b0;
            if (mWaiting) begin
                if (accept && extIndex == mWaitIdx) begin
                    mValue = extData; mValid = 1'b1; mWaiting = 1'b0;
                end else begin
                    if (accept) begin mMem[extIndex] = extData; mFull[extIndex] = 1'b1; end
                    mElapsed++;
                    if (mElapsed == int'(TO_SHORT)) begin
                        mValue = '0; mValid = 1'b1; mTimeout = 1'b1; mSticky = 1'b1; mWaiting = 1'b0;
                    end
                end
            end else begin
                if (cpuReadEnable && mFull[cpuIndex]) begin
                    mValue = mMem[cpuIndex]; mValid = 1'b1; mFull[cpuIndex] = 1'b0;
                end else if (cpuReadEnable) begin
                    mWaiting = 1'b1; mWaitIdx = cpuIndex; mElapsed = 0;
                end
                if (accept) begin mMem[extIndex] = extData; mFull[extIndex] = 1'b1; end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic ev, input logic [4:0] ei,
                                 input logic [7:0] ed, input logic re, input logic [4:0] ci,
                                 input logic cs);
        rst = r; extValid = ev; extIndex = ei; extData = ed;
        cpuReadEnable = re; cpuIndex = ci; clearStatus = cs;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0);
        cycle();
        idle();
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 5'd4, 8'hFF, 1'b1, 5'd4, 1'b1);
        cycle();
        cycle();
        idle();
        #1;
        checks++;
        if ({sBusy, sValid, sTimeout, sSticky} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {sBusy, sValid, sTimeout, sSticky});
        end
        checks++;
        if (sValue !== 8'h00) begin errors++; $display("[TB] FAIL reset_value: got %h expected 00", sValue); end
        checks++;
        if (sFull !== 32'h0) begin errors++; $display("[TB] FAIL reset_full: got %h expected 0", sFull); end
        checks++;
        if (sReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", sReady); end
    endtask

    task automatic test_read_hit();
        doReset();
        applyStimulus(1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 5'd0, 1'b0);
        cycle();
        checks++;
        if (sFull[3] !== 1'b1) begin errors++; $display("[TB] FAIL hit_fill: got %b expected 1", sFull[3]); end
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 1'b0);
        cycle();
        idle();
        checks++;
        if (sValid !== 1'b1 || sValue !== 8'hA5) begin
            errors++; $display("[TB] FAIL hit_data: got valid=%b value=%h expected valid=1 value=a5", sValid, sValue);
        end
        checks++;
        if (sFull[3] !== 1'b0) begin errors++; $display("[TB] FAIL hit_clear: got %b expected 0", sFull[3]); end
        cycle();
        checks++;
        if (sValid !== 1'b0 || sValue !== 8'hA5) begin
            errors++; $display("[TB] FAIL hit_hold: got valid=%b value=%h expected valid=0 value=a5", sValid, sValue);
        end
    endtask

    task automatic test_bypass();
        doReset();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 1'b0);
        cycle();
        idle();
        checks++;
        if (lBusy !== 1'b1) begin errors++; $display("[TB] FAIL bypass_busy: got %b expected 1", lBusy); end
        repeat (4) cycle();
        checks++;
        if (lBusy !== 1'b1 || lValid !== 1'b0) begin
            errors++; $display("[TB] FAIL bypass_stall: got busy=%b valid=%b expected busy=1 valid=0", lBusy, lValid);
        end
        applyStimulus(1'b0, 1'b1, 5'd7, 8'h3C, 1'b0, 5'd0, 1'b0);
        #1;
        checks++;
        if (lReady !== 1'b1) begin errors++; $display("[TB] FAIL bypass_ready: got %b expected 1", lReady); end
        cycle();
        idle();
        checks++;
        if (lValid !== 1'b1 || lValue !== 8'h3C || lBusy !== 1'b0 || lTimeout !== 1'b0) begin
            errors++; $display("[TB] FAIL bypass_data: got valid=%b value=%h busy=%b to=%b expected 1 3c 0 0",
                               lValid, lValue, lBusy, lTimeout);
        end
        checks++;
        if (lFull[7] !== 1'b0) begin errors++; $display("[TB] FAIL bypass_full: got %b expected 0", lFull[7]); end
    endtask

    task automatic test_full_block();
        doReset();
        applyStimulus(1'b0, 1'b1, 5'd2, 8'h11, 1'b0, 5'd0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b1, 5'd2, 8'h99, 1'b0, 5'd0, 1'b0);
        #1;
        checks++;
        if (sReady !== 1'b0) begin errors++; $display("[TB] FAIL block_ready: got %b expected 0", sReady); end
        cycle();
        applyStimulus(1'b0, 1'b0, 5'd2, 8'h00, 1'b1, 5'd2, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 5'd2, 8'h00, 1'b0, 5'd0, 1'b0);
        #1;
        checks++;
        if (sValid !== 1'b1 || sValue !== 8'h11) begin
            errors++; $display("[TB] FAIL block_mem: got valid=%b value=%h expected valid=1 value=11", sValid, sValue);
        end
        checks++;
        if (sReady !== 1'b1) begin errors++; $display("[TB] FAIL block_reopen: got %b expected 1", sReady); end
    endtask

    task automatic test_timeout();
        int edges;
        doReset();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 1'b0);
        cycle();
        idle();
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            edges++;
            if (sValid === 1'b1) break;
        end
        checks++;
        if (sValid !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_wait: got no valid pulse within %0d cycles, expected one", edges);
        end else if (edges != 4) begin
            errors++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 4", edges);
        end
        checks++;
        if (sTimeout !== 1'b1 || sValue !== 8'h00 || sSticky !== 1'b1 || sBusy !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_flags: got to=%b value=%h sticky=%b busy=%b expected 1 00 1 0",
                               sTimeout, sValue, sSticky, sBusy);
        end
        repeat (3) cycle();
        checks++;
        if (sSticky !== 1'b1 || sTimeout !== 1'b0) begin
            errors++; $display("[TB] FAIL sticky_hold: got sticky=%b to=%b expected 1 0", sSticky, sTimeout);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1);
        cycle();
        idle();
        checks++;
        if (sSticky !== 1'b0) begin errors++; $display("[TB] FAIL sticky_clear: got %b expected 0", sSticky); end
    endtask

    task automatic test_reset_in_wait();
        doReset();
        applyStimulus(1'b0, 1'b1, 5'd1, 8'h77, 1'b1, 5'd5, 1'b0);
        cycle();
        idle();
        cycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1);
        cycle();
        idle();
        checks++;
        if (sBusy !== 1'b0 || sValid !== 1'b0 || sFull !== 32'h0) begin
            errors++; $display("[TB] FAIL rst_wait: got busy=%b valid=%b full=%h expected 0 0 0", sBusy, sValid, sFull);
        end
        cycle();
        checks++;
        if (sValid !== 1'b0 || sTimeout !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_wait_quiet: got valid=%b to=%b expected 0 0", sValid, sTimeout);
        end
    endtask

    task automatic test_bypass_at_expiry();
        doReset();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 1'b0);
        cycle();
        idle();
        repeat (3) cycle();
        applyStimulus(1'b0, 1'b1, 5'd9, 8'h5A, 1'b0, 5'd0, 1'b0);
        cycle();
        idle();
        checks++;
        if (sValid !== 1'b1 || sValue !== 8'h5A || sTimeout !== 1'b0 || sSticky !== 1'b0) begin
            errors++; $display("[TB] FAIL expiry_bypass: got valid=%b value=%h to=%b sticky=%b expected 1 5a 0 0",
                               sValid, sValue, sTimeout, sSticky);
        end
    endtask

    task automatic checkOutput(input int n);
        checks++;
        if (sValid !== mValid || sTimeout !== mTimeout || sBusy !== mWaiting || sSticky !== mSticky) begin
            errors++; $display("[TB] FAIL rand_flags[%0d]: got v=%b t=%b b=%b s=%b expected v=%b t=%b b=%b s=%b",
                               n, sValid, sTimeout, sBusy, sSticky, mValid, mTimeout, mWaiting, mSticky);
        end
        checks++;
        if (sValue !== mValue || sFull !== mFull) begin
            errors++; $display("[TB] FAIL rand_data[%0d]: got value=%h full=%h expected value=%h full=%h",
                               n, sValue, sFull, mValue, mFull);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                          5'($urandom_range(0, 7)), 8'($urandom),
                          ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
                          ($urandom_range(0, 15) == 0));
            #1;
            checks++;
            if (sReady !== modelReady(extIndex)) begin
                errors++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", n, sReady, modelReady(extIndex));
            end
            cycle();
            checkOutput(n);
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mMem[i] = '0;
        idle();
        test_reset();
        test_read_hit();
        test_bypass();
        test_full_block();
        test_timeout();
        test_reset_in_wait();
        test_bypass_at_expiry();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
